// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the IF/ID pipeline register: the NOP
//               encoding for nullified slots, the occupancy encoding, and the
//               layout of one buffered entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  // Instruction word presented to decode in place of a nullified instruction.
  localparam logic [31:0] NOP_INST = 32'h0800_0240;

  // Buffer occupancy: ONE means only main is valid, FULL means main and skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  // An entry is the concatenation {null, pc, inst}, MSB first. The widths
  // are parameters of the users, so the layout is expressed as a width helper.
  function automatic int entry_width(input int inst_w, input int pc_w);
    return 1 + pc_w + inst_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_pipe_if.sv
// ============================================================================
// Module      : if_id_pipe_if
// Description : Bundle of the fetch-side and decode-side handshake, data and
//               control signals around the IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_id_pipe_if #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] Inst_in;
  logic [PC_W-1:0]   PC_Front;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] Inst_out;
  logic [PC_W-1:0]   PC_Front_out;
  logic              Null_out;
  logic              flush;
  logic              nullify;

  // Pipeline register side.
  modport slave (
    input  in_valid, Inst_in, PC_Front, out_ready, flush, nullify,
    output in_ready, out_valid, Inst_out, PC_Front_out, Null_out
  );

  // Surrounding stages (fetch source, decode sink, hazard control).
  modport master (
    output in_valid, Inst_in, PC_Front, out_ready, flush, nullify,
    input  in_ready, out_valid, Inst_out, PC_Front_out, Null_out
  );

endinterface

`default_nettype wire

// File: rtl/pipe_entry_reg.sv
// ============================================================================
// Module      : pipe_entry_reg
// Description : One buffered pipeline entry: valid flag plus {null, pc, inst}.
//               Supports load, clear (drops valid and null, keeps data) and
//               mark (turns the held instruction into a NOP).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  localparam int ENT_W = 1 + PC_W + INST_W
) (
  input  wire logic             clk,
  input  wire logic             Reset,
  input  wire logic             load_i,
  input  wire logic             clr_i,
  input  wire logic             mark_i,
  input  wire logic [ENT_W-1:0] entry_i,
  output logic                  valid_o,
  output logic      [ENT_W-1:0] entry_o
);

  localparam logic [INST_W-1:0] NOP_VAL = INST_W'(NOP_INST);

  logic             valid_q;
  logic [ENT_W-1:0] entry_q;

  // Clear beats load beats mark; the data field is retained on clear so an
  // emptied buffer keeps showing its last instruction and PC.
  always_ff @(posedge clk) begin
    if (Reset) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (clr_i) begin
      valid_q          <= 1'b0;
      entry_q[ENT_W-1] <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      entry_q <= entry_i;
    end else if (mark_i) begin
      entry_q[ENT_W-1]    <= 1'b1;
      entry_q[INST_W-1:0] <= NOP_VAL;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

`default_nettype wire

// File: rtl/if_id_pipe.sv
// ============================================================================
// Module      : if_id_pipe
// Description : IF/ID pipeline register with valid/ready handshake, 2-entry
//               skid buffer, flush and PA-RISC style nullification.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_pipe
  import pipe_pkg::*;
#(
  parameter int INST_W = 32,
  parameter int PC_W   = 32
) (
  input  wire logic   clk,
  input  wire logic   Reset,
  if_id_pipe_if.slave bus
);

  localparam int ENT_W = entry_width(INST_W, PC_W);
  localparam logic [INST_W-1:0] NOP_VAL = INST_W'(NOP_INST);

  occ_e state_q, state_d;
  logic pend_q, pend_d;
  logic in_ready_q;

  logic in_xfer, out_xfer;
  logic null_now, hold_out, pend_eff;
  logic main_load, main_clr, main_mark;
  logic skid_load, skid_clr;
  logic main_valid, skid_valid;
  logic [ENT_W-1:0] main_ent, skid_ent, in_ent, main_src, main_ent_d;

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = main_valid & bus.out_ready;

  // Flush suppresses nullify. A held, stalled output gets marked in place;
  // otherwise the request applies to whatever is loaded into main next,
  // including an entry loaded in this very cycle.
  assign null_now = bus.nullify & ~bus.flush;
  assign hold_out = main_valid & ~bus.out_ready;
  assign pend_eff = pend_q | (null_now & ~hold_out);

  assign in_ent     = {1'b0, bus.PC_Front, bus.Inst_in};
  assign main_src   = skid_valid ? skid_ent : in_ent;
  assign main_ent_d = pend_eff ? {1'b1, main_src[ENT_W-2:INST_W], NOP_VAL} : main_src;

  // Occupancy, pending-nullify flag and registered ready.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= EMPTY;
      pend_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Next occupancy and entry-register controls.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_clr  = 1'b0;
    main_mark = null_now & hold_out;
    skid_load = 1'b0;
    skid_clr  = 1'b0;

    if (bus.flush) begin
      state_d   = EMPTY;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
      main_mark = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (out_xfer) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_load = 1'b1;
            skid_clr  = 1'b1;
            state_d   = ONE;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end

    if (bus.flush || main_load) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_eff;
    end
  end

  pipe_entry_reg #(.INST_W(INST_W), .PC_W(PC_W)) u_main (
    .clk     (clk),
    .Reset   (Reset),
    .load_i  (main_load),
    .clr_i   (main_clr),
    .mark_i  (main_mark),
    .entry_i (main_ent_d),
    .valid_o (main_valid),
    .entry_o (main_ent)
  );

  pipe_entry_reg #(.INST_W(INST_W), .PC_W(PC_W)) u_skid (
    .clk     (clk),
    .Reset   (Reset),
    .load_i  (skid_load),
    .clr_i   (skid_clr),
    .mark_i  (1'b0),
    .entry_i (in_ent),
    .valid_o (skid_valid),
    .entry_o (skid_ent)
  );

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = main_valid;
  assign bus.Null_out     = main_ent[ENT_W-1];
  assign bus.PC_Front_out = main_ent[ENT_W-2:INST_W];
  assign bus.Inst_out     = main_ent[INST_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_if_id_pipe.sv
// ============================================================================
// Module      : tb_if_id_pipe
// Description : Directed bench for if_id_pipe: streaming, stall fill, flush,
//               nullify (held and pending), nullify+flush, reset mid-FULL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_pipe;

  localparam logic [31:0] NOP = 32'h0800_0240;

  logic clk;
  logic Reset;
  int   n_vec;
  int   n_err;

  if_id_pipe_if #(.INST_W(32), .PC_W(32)) bus ();

  if_id_pipe #(.INST_W(32), .PC_W(32)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a beat (instruction derived from PC) and advance one cycle.
  task automatic push(input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.PC_Front = pc;
    bus.Inst_in  = 32'hB000_0000 | pc;
    step();
  endtask

  task automatic out_is(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] inst, input logic nul);
    chk({tag, ".valid"}, bus.out_valid, v);
    chk({tag, ".pc"},    bus.PC_Front_out, pc);
    chk({tag, ".inst"},  bus.Inst_out, inst);
    chk({tag, ".null"},  bus.Null_out, nul);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.Inst_in   = '0;
    bus.PC_Front  = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.nullify   = 1'b0;

    // Reset for two cycles.
    step();
    out_is("rst", 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst.in_ready", bus.in_ready, 1'b0);
    step();
    chk("rst2.in_ready", bus.in_ready, 1'b0);
    Reset = 1'b0;
    step();
    chk("post_rst.in_ready", bus.in_ready, 1'b1);
    chk("post_rst.valid", bus.out_valid, 1'b0);

    // Streaming at full rate.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.PC_Front  = 32'h100;
    bus.Inst_in   = 32'hA000_0001;
    step();
    out_is("stream1", 1'b1, 32'h100, 32'hA000_0001, 1'b0);
    bus.PC_Front = 32'h104;
    bus.Inst_in  = 32'hA000_0002;
    step();
    out_is("stream2", 1'b1, 32'h104, 32'hA000_0002, 1'b0);
    chk("stream2.in_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b0;
    step();
    chk("stream_drain.valid", bus.out_valid, 1'b0);

    // Stall fill: two accepted, third held by fetch.
    bus.out_ready = 1'b0;
    push(32'h100);
    out_is("fill1", 1'b1, 32'h100, 32'hB000_0100, 1'b0);
    chk("fill1.in_ready", bus.in_ready, 1'b1);
    push(32'h104);
    chk("fill2.in_ready", bus.in_ready, 1'b0);
    chk("fill2.pc", bus.PC_Front_out, 32'h100);
    push(32'h108);
    chk("fill3.in_ready", bus.in_ready, 1'b0);
    out_is("fill3", 1'b1, 32'h100, 32'hB000_0100, 1'b0);
    bus.out_ready = 1'b1;
    step();
    out_is("drain1", 1'b1, 32'h104, 32'hB000_0104, 1'b0);
    chk("drain1.in_ready", bus.in_ready, 1'b1);
    step();
    out_is("drain2", 1'b1, 32'h108, 32'hB000_0108, 1'b0);
    bus.in_valid = 1'b0;
    step();
    chk("drain3.valid", bus.out_valid, 1'b0);

    // Flush while FULL; incoming 0x208 must vanish.
    bus.out_ready = 1'b0;
    push(32'h200);
    push(32'h204);
    chk("ffull.in_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b1;
    bus.PC_Front = 32'h208;
    bus.Inst_in  = 32'hB000_0208;
    bus.flush    = 1'b1;
    step();
    out_is("flush", 1'b0, 32'h200, 32'hB000_0200, 1'b0);
    chk("flush.in_ready", bus.in_ready, 1'b1);
    // Flush with a beat actually accepted in the flush cycle.
    step();
    chk("flush_xfer.valid", bus.out_valid, 1'b0);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("flush_after.valid", bus.out_valid, 1'b0);

    // Nullify a held, stalled output.
    bus.out_ready = 1'b0;
    push(32'h300);
    out_is("nh_pre", 1'b1, 32'h300, 32'hB000_0300, 1'b0);
    bus.in_valid = 1'b0;
    bus.nullify  = 1'b1;
    step();
    bus.nullify = 1'b0;
    out_is("nh_mark", 1'b1, 32'h300, NOP, 1'b1);
    push(32'h304);
    out_is("nh_hold", 1'b1, 32'h300, NOP, 1'b1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    out_is("nh_next", 1'b1, 32'h304, 32'hB000_0304, 1'b0);
    step();
    chk("nh_empty.valid", bus.out_valid, 1'b0);
    chk("nh_empty.null", bus.Null_out, 1'b0);

    // Nullify while EMPTY applies to the next entry only.
    bus.out_ready = 1'b0;
    bus.nullify   = 1'b1;
    step();
    bus.nullify = 1'b0;
    chk("ne_idle.null", bus.Null_out, 1'b0);
    push(32'h400);
    out_is("ne_first", 1'b1, 32'h400, NOP, 1'b1);
    bus.out_ready = 1'b1;
    push(32'h404);
    out_is("ne_second", 1'b1, 32'h404, 32'hB000_0404, 1'b0);
    bus.in_valid = 1'b0;
    step();

    // Nullify and flush together: nothing nullified afterwards.
    bus.nullify = 1'b1;
    bus.flush   = 1'b1;
    step();
    bus.nullify = 1'b0;
    bus.flush   = 1'b0;
    push(32'h410);
    out_is("nf", 1'b1, 32'h410, 32'hB000_0410, 1'b0);
    bus.in_valid = 1'b0;
    step();

    // Reset while FULL.
    bus.out_ready = 1'b0;
    push(32'h500);
    push(32'h504);
    chk("rf_full.in_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;
    Reset = 1'b1;
    step();
    out_is("rf", 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rf.in_ready", bus.in_ready, 1'b0);
    Reset = 1'b0;
    step();
    chk("rf_after.in_ready", bus.in_ready, 1'b1);
    chk("rf_after.valid", bus.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_id_pipe.md
Name: if_id_pipe

Overview:
Parametrised successor to the fetch/decode pipeline register. It replaces the plain load-enable register with a valid/ready handshake, backed by a 2-entry skid buffer, so fetch can run at full rate while decode stalls. It adds flush (branch mispredict or trap) and PA-RISC nullification, which presents the next instruction as a NOP. It sits between the IF stage (PC/IMEM) and the ID stage (decoder/register file).

Parameters:
INST_W, 32, instruction width
PC_W, 32, PC (front) width
NOP_INST, 32'h0800_0240, encoding presented for a nullified instruction; defined in shared package

Ports:
clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
in_valid  in  1  IF presents a beat
in_ready  out  1  buffer can accept; registered, equals !skid_valid
Inst_in  in  INST_W  fetched instruction
PC_Front  in  PC_W  PC of Inst_in
out_valid  out  1  ID-side entry valid
out_ready  in  1  ID consumes the beat
Inst_out  out  INST_W  instruction to ID; NOP_INST when nullified
PC_Front_out  out  PC_W  PC of the output entry
Null_out  out  1  output entry is nullified
flush  in  1  discard all held and incoming beats
nullify  in  1  nullify the output entry, or the next entry if none is held

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, sampled on the rising clk edge.
- Reset values: out_valid=0, in_ready=0 during the reset cycle and 1 from the first cycle after; Inst_out=0, PC_Front_out=0, Null_out=0; skid empty; pending-nullify flag=0.
- Storage: main entry (drives the outputs) and skid entry. Occupancy states: EMPTY (0), ONE (main valid), FULL (main and skid valid).
- Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- Latency: 1 cycle from in_xfer to out_valid when EMPTY.
- State transitions:
  - EMPTY: in_xfer -> main<=in, go to ONE.
  - ONE, in_xfer & out_xfer -> main<=in, stay ONE (full throughput).
  - ONE, in_xfer & !out_xfer -> skid<=in, go to FULL; in_ready=0 next cycle.
  - ONE, !in_xfer & out_xfer -> go to EMPTY.
  - FULL: in_ready=0. out_xfer -> main<=skid, go to ONE, in_ready=1 next cycle.
- Stability: while out_valid & !out_ready, Inst_out, PC_Front_out and Null_out hold stable. When EMPTY, data outputs hold their last value.
- Ordering: beats leave in acceptance order; none are dropped except by flush.
- Flush: priority below Reset, above everything else. Next state EMPTY, skid cleared, pending-nullify cleared, Null_out=0, data outputs hold.
  - A beat with in_xfer in the flush cycle is discarded.
  - out_xfer in the flush cycle still counts as consumed by ID.
  - in_ready=1 the cycle after flush.
- Nullify, out_valid=1 and no out_xfer this cycle: main entry marked null. From the next cycle, Inst_out=NOP_INST and Null_out=1; PC_Front_out is unchanged.
- Nullify, otherwise (no valid output entry, or it transfers this same cycle): pending flag set. The next entry loaded into main is marked null and the flag clears.
- Null lifetime: the null mark clears when that entry transfers out. Repeated nullify while an entry is already null has no extra effect.
- Nullify & flush in the same cycle: flush wins and nullify is ignored.
- Reset mid-operation (any state): returns to EMPTY next cycle; all held beats are lost.

Decomposition:
- Shared package pipe_pkg holds: NOP_INST; the occupancy enum {EMPTY, ONE, FULL} (2 bits); and a struct/concat layout {null, pc, inst} for one entry.
- Natural sub-module: pipe_entry_reg, one valid+null+data register with load and clear. Instantiated twice (main, skid).

Test Plan:
- Reset then streaming: Reset 2 cycles; push 0xA0000001@PC 0x100 and 0xA0000002@PC 0x104 back-to-back with out_ready=1 -> out_valid from cycle 1 after the first push; outputs in order, 1 beat/cycle, Null_out=0.
- Stall fill: out_ready=0, push 3 beats -> two accepted (EMPTY->ONE->FULL), in_ready=0 after the second, third held by IF. Raise out_ready -> 0x100, 0x104, 0x108 delivered in order with no loss or duplication.
- Flush while FULL: FULL with 0x200/0x204, assert flush with in_valid at 0x208 -> next cycle out_valid=0, in_ready=1; 0x208 never appears at the output.
- Nullify held output: output 0x300 stalled, pulse nullify -> next cycle Inst_out=NOP_INST, PC_Front_out=0x300, Null_out=1. After out_xfer, following entry 0x304 shows Null_out=0.
- Nullify when EMPTY: pulse nullify, then push 0x400 -> output shows NOP_INST with Null_out=1 for 0x400 only. Nullify & flush in the same cycle -> nothing nullified afterwards.
- Reset mid-FULL: Reset while FULL -> next cycle out_valid=0, Inst_out=0, PC_Front_out=0, in_ready=0 during reset and 1 after.
